fmul32_arb: RTL
===============

// Module: fmul32_arb
// PURPOSE
//  Shares one multi-cycle FP32 multiplier core among N_REQ requesters.
//  Round-robin arbitration, operand classification and special-case bypass
//  (NaN/Inf/zero/denormal never reach the core), start/done sequencing of
//  the core, and per-requester response return.
//  Sits between the client ports and the FMUL32 datapath.
// PARAMETERS
//  N_REQ    4    number of requesters (2..8)
//  TIMEOUT  64   max cycles in WAIT before the block aborts the operation
// PORTS
//  clk          in   1         clock; all state updates on rising edge
//  rst          in   1         synchronous, active-high reset
//  req_valid    in   N_REQ     request pending, one bit per requester
//  req_ready    out  N_REQ     one-hot grant; the transfer happens when valid&ready
//  req_op_a     in   32*N_REQ  operand A, requester i at [32i+31:32i]
//  req_op_b     in   32*N_REQ  operand B, same packing
//  rsp_valid    out  N_REQ     one-hot; result is valid for that requester
//  rsp_ready    in   N_REQ     requester accepts the result
//  rsp_res      out  32        result (shared bus, qualified by rsp_valid)
//  rsp_err      out  1         result was produced by a timeout abort
//  mul_start    out  1         single-cycle start pulse to the core
//  mul_a/mul_b  out  32        operands to the core, held stable from start to done
//  mul_done     in   1         single-cycle completion pulse from the core
//  mul_res      in   32        core result, valid while mul_done=1
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, tmo_cnt=0; req_ready, rsp_valid, rsp_err,
//   mul_start=0; mul_a, mul_b, rsp_res=0.
//  Operand class codes: NAN=0, ZERO=1, NORM=2, DENORM=3, INF=4.
//  FSM:
//  - IDLE: grant the first i with req_valid[i], scanning from rr_ptr upward
//   and wrapping at N_REQ. req_ready is combinational, driven only in IDLE.
//   On grant, latch the operands and the id, then go to DECODE.
//  - DECODE: classify both latched operands. Priority order:
//   - either operand NAN, or ZERO/DENORM x INF -> res=32'h7FC00000
//   - either operand INF -> {sA^sB, 8'hFF, 23'h0}
//   - either operand ZERO/DENORM (flush-to-zero) -> {sA^sB, 31'h0}
//   Any of these -> RESP. Both operands NORM -> ISSUE.
//  - ISSUE: mul_start=1 for exactly one cycle; tmo_cnt=0; go to WAIT.
//  - WAIT: on mul_done, latch mul_res into rsp_res and go to RESP.
//   Otherwise tmo_cnt++. At tmo_cnt==TIMEOUT-1 without done:
//   res=32'h7FC00000, rsp_err=1, go to RESP.
//  - RESP: hold rsp_valid[id]=1 and rsp_res stable until rsp_ready[id].
//   On that cycle: rr_ptr=(id+1) mod N_REQ, clear rsp_err, go to IDLE.
//  Latency, request accepted at edge 0:
//  - special-case rsp_valid high at cycle 2;
//  - mul_start high in cycle 2; rsp_valid high the cycle after mul_done.
//  Throughput: one operation in flight. No new grant until the response is
//   consumed, so req_ready=0 in every state except IDLE.
//  Boundaries:
//  - mul_done outside WAIT is ignored, including a late done after a timeout.
//  - mul_done in the same cycle as the timeout count: done wins, rsp_err=0.
//  - rsp_ready of non-selected requesters is ignored.
//  - rst mid-operation returns to the reset state at once. An in-flight core
//   op is abandoned and its later done is ignored.
//  - rr_ptr advances only on a completed response. Sole requester i is
//   re-granted every time.
// STRUCTURE
//  Package fmul32_pkg: class codes, QNAN/INF/ZERO constants,
//   FSM state encoding.
//  Sub-module fp32_class: combinational op[31:0] -> class[4:0] and
//   mant[23:0] (hidden bit set only for NORM). Instantiated twice.
//  RR pick is a function in the package; the FSM and counters are in this file.
// TESTING
//  - rst; req_valid=0001, A=3F800000, B=40000000; core model done after 5
//    cycles with 40000000 -> mul_start once at cycle 2, rsp_valid=0001,
//    rsp_res=40000000, rsp_err=0.
//  - A=7F800000, B=00000000 -> no mul_start; rsp_res=7FC00000 at cycle 2.
//    A=FF800000, B=3F800000 -> FF800000. A=80000001, B=3F800000 -> 80000000.
//  - req_valid=1111 held for 8 NORM ops -> grant order 0,1,2,3,0,1,2,3.
//    Each req_ready is exactly one cycle.
//  - Core never asserts done; TIMEOUT=8 -> rsp_res=7FC00000, rsp_err=1.
//    A done injected later in IDLE changes nothing.
//  - rsp_ready held low for 10 cycles -> rsp_valid and rsp_res stable,
//    req_ready stays 0.
//  - rst asserted in WAIT -> next cycle all outputs at reset values; the next
//    grant goes to requester 0.

Source files
------------

// File: rtl/fmul32_pkg.sv
// ----------------------------------------------------------------------------
// fmul32_pkg
//  Shared definitions for the FP32 multiplier arbiter:
//   - operand class codes (bit positions of the one-hot class vector)
//   - special-result constants (quiet NaN, infinity magnitude)
//   - FSM state encoding
//   - rr_pick: round-robin selection helper
// ----------------------------------------------------------------------------
package fmul32_pkg;

    // Class codes; each code is also the bit index in the one-hot class vector.
    localparam int N_CLS      = 5;
    localparam int CLS_NAN    = 0;
    localparam int CLS_ZERO   = 1;
    localparam int CLS_NORM   = 2;
    localparam int CLS_DENORM = 3;
    localparam int CLS_INF    = 4;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [30:0] INF_MAG = {8'hFF, 23'h0};
    localparam logic [30:0] ZERO_MAG = 31'h0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    // First set bit of valid[n-1:0], scanning upward from ptr and wrapping
    // at n. Returns 0 when nothing is set (caller gates with |valid).
    function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                           input logic [2:0] ptr,
                                           input int         n);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !found && valid[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fp32_class.sv
// ----------------------------------------------------------------------------
// fp32_class
//  Combinational FP32 operand classifier.
//  Ports:
//   op    in   32  IEEE-754 single-precision operand
//   cls   out  5   one-hot class, bit index = class code from fmul32_pkg
//   mant  out  24  significand with hidden bit (hidden bit set only for NORM)
// ----------------------------------------------------------------------------
module fp32_class
    import fmul32_pkg::*;
(
    input  logic [31:0]      op,
    output logic [N_CLS-1:0] cls,
    output logic [23:0]      mant
);

    logic [7:0]  exp_f;
    logic [22:0] frac;

    assign exp_f = op[30:23];
    assign frac  = op[22:0];

    always_comb begin
        // NOTE: default assignment first so every path drives cls; an
        // incomplete if/else in always_comb would otherwise infer a latch.
        cls = '0;
        if (exp_f == 8'hFF) begin
            if (frac != 23'h0) cls[CLS_NAN] = 1'b1;
            else               cls[CLS_INF] = 1'b1;
        end else if (exp_f == 8'h00) begin
            if (frac != 23'h0) cls[CLS_DENORM] = 1'b1;
            else               cls[CLS_ZERO]   = 1'b1;
        end else begin
            cls[CLS_NORM] = 1'b1;
        end
    end

    assign mant = {cls[CLS_NORM], frac};

endmodule

// File: rtl/fmul32_arb.sv
// ----------------------------------------------------------------------------
// fmul32_arb
//  Shares one multi-cycle FP32 multiplier core among N_REQ requesters.
//  Round-robin grant, special-case bypass (NaN/Inf/zero/denormal are answered
//  locally), start/done sequencing with a timeout abort, and response return.
//  Ports:
//   clk, rst     clock; synchronous active-high reset
//   req_valid    in   N_REQ     request pending per requester
//   req_ready    out  N_REQ     one-hot grant (combinational, IDLE only)
//   req_op_a/b   in   32*N_REQ  operands, requester i at [32i+31:32i]
//   rsp_valid    out  N_REQ     one-hot response valid
//   rsp_ready    in   N_REQ     response accepted
//   rsp_res      out  32        shared result bus
//   rsp_err      out  1         result came from a timeout abort
//   mul_start    out  1         one-cycle start pulse to the core
//   mul_a/mul_b  out  32        core operands, held for the whole operation
//   mul_done     in   1         one-cycle completion pulse from the core
//   mul_res      in   32        core result, valid with mul_done
// ----------------------------------------------------------------------------
module fmul32_arb
    import fmul32_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_op_a,
    input  logic [32*N_REQ-1:0]  req_op_b,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [31:0]          rsp_res,
    output logic                 rsp_err,
    output logic                 mul_start,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    input  logic                 mul_done,
    input  logic [31:0]          mul_res
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   id;
    logic [TW-1:0]    tmo_cnt;
    logic [IDW-1:0]   pick;
    logic [N_REQ-1:0] id_onehot;
    logic [IDW-1:0]   rr_next;

    logic [N_CLS-1:0] cls_a, cls_b;
    logic [23:0]      mant_a, mant_b;
    logic             unused_mant;

    // The latched operands double as the core operands, so classification
    // runs on exactly what the core would see.
    fp32_class u_class_a (.op(mul_a), .cls(cls_a), .mant(mant_a));
    fp32_class u_class_b (.op(mul_b), .cls(cls_b), .mant(mant_b));

    assign unused_mant = ^{mant_a, mant_b};

    logic nan_any, inf_a, inf_b, zd_a, zd_b, norm_both, res_sign;
    assign nan_any   = cls_a[CLS_NAN] | cls_b[CLS_NAN];
    assign inf_a     = cls_a[CLS_INF];
    assign inf_b     = cls_b[CLS_INF];
    assign zd_a      = cls_a[CLS_ZERO] | cls_a[CLS_DENORM];
    assign zd_b      = cls_b[CLS_ZERO] | cls_b[CLS_DENORM];
    assign norm_both = cls_a[CLS_NORM] & cls_b[CLS_NORM];
    assign res_sign  = mul_a[31] ^ mul_b[31];

    assign pick      = IDW'(rr_pick(8'(req_valid), 3'(rr_ptr), N_REQ));
    assign id_onehot = N_REQ'(1) << id;
    assign rr_next   = (id == IDW'(N_REQ - 1)) ? '0 : id + IDW'(1);

    // Grant is combinational so a requester sees ready in the same cycle it
    // is picked; gated by rst so nothing is granted while in reset.
    always_comb begin
        req_ready = '0;
        if (!rst && state == S_IDLE && |req_valid) req_ready[pick] = 1'b1;
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            id        <= '0;
            tmo_cnt   <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_res   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        id    <= pick;
                        mul_a <= req_op_a[32*pick +: 32];
                        mul_b <= req_op_b[32*pick +: 32];
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (nan_any || (zd_a && inf_b) || (zd_b && inf_a)) begin
                        rsp_res   <= QNAN;
                        rsp_valid <= id_onehot;
                        state     <= S_RESP;
                    end else if (inf_a || inf_b) begin
                        rsp_res   <= {res_sign, INF_MAG};
                        rsp_valid <= id_onehot;
                        state     <= S_RESP;
                    end else if (zd_a || zd_b) begin
                        // Denormals are flushed to zero.
                        rsp_res   <= {res_sign, ZERO_MAG};
                        rsp_valid <= id_onehot;
                        state     <= S_RESP;
                    end else if (norm_both) begin
                        mul_start <= 1'b1;
                        state     <= S_ISSUE;
                    end else begin
                        // Unreachable: the classes above are exhaustive.
                        rsp_res   <= QNAN;
                        rsp_valid <= id_onehot;
                        state     <= S_RESP;
                    end
                end
                S_ISSUE: begin
                    mul_start <= 1'b0;
                    tmo_cnt   <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    // done is checked first so a done on the last count wins.
                    if (mul_done) begin
                        rsp_res   <= mul_res;
                        rsp_valid <= id_onehot;
                        state     <= S_RESP;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        rsp_res   <= QNAN;
                        rsp_err   <= 1'b1;
                        rsp_valid <= id_onehot;
                        state     <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready[id]) begin
                        rsp_valid <= '0;
                        rsp_err   <= 1'b0;
                        rr_ptr    <= rr_next;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
